viterbi_traceback: RTL and testbench

Traceback stage of the Viterbi decoder, directly downstream of `trellis_diagr`. It is handed the best end state and a window length. It then walks the stored survivor (predecessor-state) memory backwards, one trellis step at a time, and recovers the decoded input bits. It emits those bits in forward time order over a valid/ready stream.

---
 rtl/viterbi_traceback.sv | 127 ++++++++++++
 tb/tb_viterbi_traceback.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_traceback.sv
// Viterbi traceback: walks the survivor memory backwards from a given end state and
// streams the recovered input bits out in forward time order over valid/ready.
module viterbi_traceback #(
    parameter int unsigned ST_W  = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned LEN_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_tb,
    input  logic             i_start,
    input  logic [ST_W-1:0]  i_start_st,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_rd_en,
    output logic [LEN_W-1:0] o_rd_addr,
    output logic [ST_W-1:0]  o_rd_st,
    input  logic [ST_W-1:0]  i_prv_st,
    output logic             o_bit,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_last,
    output logic             o_busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] CAP  = 2'd2;
    localparam logic [1:0] EMIT = 2'd3;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DEPTH);

    logic [1:0]       state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [LEN_W-1:0] oidx_q, oidx_d;
    logic [ST_W-1:0]  cur_st_q, cur_st_d;
    logic [DEPTH-1:0] buf_q, buf_d;
    logic             out_bit;
    logic             is_last;

    // Explicit compare-based mux keeps the index width independent of DEPTH.
    always_comb begin
        out_bit = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (oidx_q == LEN_W'(i)) begin
                out_bit = buf_q[i];
            end
        end
        is_last = (oidx_q == len_q - LEN_W'(1));
    end

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        idx_d    = idx_q;
        oidx_d   = oidx_q;
        cur_st_d = cur_st_q;
        buf_d    = buf_q;
        if (en_tb) begin
            case (state_q)
                IDLE: begin
                    if (i_start && (i_len != '0)) begin
                        len_d    = (i_len > MAX_LEN) ? MAX_LEN : i_len;
                        cur_st_d = i_start_st;
                        idx_d    = len_d - LEN_W'(1);
                        state_d  = RD;
                    end
                end
                RD: state_d = CAP;
                CAP: begin
                    // The bit decoded at step idx is the MSB of the state at idx+1.
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        if (idx_q == LEN_W'(i)) begin
                            buf_d[i] = cur_st_q[ST_W-1];
                        end
                    end
                    cur_st_d = i_prv_st;
                    if (idx_q == '0) begin
                        oidx_d  = '0;
                        state_d = EMIT;
                    end else begin
                        idx_d   = idx_q - LEN_W'(1);
                        state_d = RD;
                    end
                end
                EMIT: begin
                    if (i_ready) begin
                        if (is_last) begin
                            state_d = IDLE;
                        end else begin
                            oidx_d = oidx_q + LEN_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            len_q    <= '0;
            idx_q    <= '0;
            oidx_q   <= '0;
            cur_st_q <= '0;
            buf_q    <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            oidx_q   <= oidx_d;
            cur_st_q <= cur_st_d;
            buf_q    <= buf_d;
        end
    end

    // Strobes are gated by the enable so a stalled cycle never issues a read or a transfer.
    assign o_rd_en   = en_tb && (state_q == RD);
    assign o_rd_addr = idx_q;
    assign o_rd_st   = cur_st_q;
    assign o_bit     = out_bit;
    assign o_valid   = en_tb && (state_q == EMIT);
    assign o_last    = (state_q == EMIT) && is_last;
    assign o_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_viterbi_traceback.sv
// Directed bench for viterbi_traceback: a survivor-memory walk model predicts every read
// and output bit, and literal cycle/bit expectations pin that model.
module tb_viterbi_traceback;

    localparam int ST_W  = 2;
    localparam int DEPTH = 8;
    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en_tb = 1'b1;
    logic             i_start = 1'b0;
    logic [ST_W-1:0]  i_start_st = '0;
    logic [LEN_W-1:0] i_len = '0;
    logic             o_rd_en;
    logic [LEN_W-1:0] o_rd_addr;
    logic [ST_W-1:0]  o_rd_st;
    logic [ST_W-1:0]  i_prv_st = '0;
    logic             o_bit;
    logic             o_valid;
    logic             i_ready = 1'b1;
    logic             o_last;
    logic             o_busy;

    viterbi_traceback #(
        .ST_W (ST_W),
        .DEPTH(DEPTH),
        .LEN_W(LEN_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en_tb     (en_tb),
        .i_start   (i_start),
        .i_start_st(i_start_st),
        .i_len     (i_len),
        .o_rd_en   (o_rd_en),
        .o_rd_addr (o_rd_addr),
        .o_rd_st   (o_rd_st),
        .i_prv_st  (i_prv_st),
        .o_bit     (o_bit),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_last    (o_last),
        .o_busy    (o_busy)
    );

    logic [ST_W-1:0] mem [DEPTH][4];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int t0  = 0;

    int         exp_addr[$];
    logic [1:0] exp_st[$];
    int         exp_bit[$];
    int         exp_last[$];

    int rd_cyc[$];
    int rd_addr_log[$];
    int bit_log[$];
    int bit_cyc[$];
    int last_cyc;
    int done_cyc;

    int en_a, en_b, en2_a, en2_b, rdy_a, rdy_b, bs1, bs2, rst_at;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (o_rd_en) i_prv_st <= mem[o_rd_addr[2:0]][o_rd_st];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_seq(input string name, input int got[$], input int exp[8],
                             input int n);
        check({name, "_count"}, got.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < got.size()) check(name, got[i], exp[i]);
        end
    endtask

    // Reference: follow predecessors back from the end state; bit t is MSB of state t+1.
    task automatic model_load(input logic [1:0] st, input int len);
        int         l;
        logic [1:0] s;
        int         bits[DEPTH];
        exp_addr.delete(); exp_st.delete(); exp_bit.delete(); exp_last.delete();
        l = (len > DEPTH) ? DEPTH : len;
        s = st;
        for (int t = l - 1; t >= 0; t--) begin
            exp_addr.push_back(t);
            exp_st.push_back(s);
            bits[t] = int'(s[1]);
            s = mem[t][s];
        end
        for (int t = 0; t < l; t++) begin
            exp_bit.push_back(bits[t]);
            exp_last.push_back(int'(t == l - 1));
        end
    endtask

    always @(negedge clk) begin
        int rel;
        rel = cyc - t0 + 1;
        if (rst) begin
            if (!en_tb) check("stall_gate", int'(o_rd_en | o_valid), 0);
            if (o_rd_en) begin
                if (exp_addr.size() == 0) begin
                    check("extra_read", 1, 0);
                end else begin
                    check("rd_addr", o_rd_addr, exp_addr[0]);
                    check("rd_st", o_rd_st, exp_st[0]);
                    void'(exp_addr.pop_front());
                    void'(exp_st.pop_front());
                end
                rd_cyc.push_back(rel);
                rd_addr_log.push_back(int'(o_rd_addr));
            end
            if (o_valid) begin
                if (exp_bit.size() == 0) begin
                    check("extra_bit", 1, 0);
                end else begin
                    check("o_bit", o_bit, exp_bit[0]);
                    check("o_last", o_last, exp_last[0]);
                    if (i_ready) begin
                        void'(exp_bit.pop_front());
                        void'(exp_last.pop_front());
                    end
                end
                if (i_ready) begin
                    bit_log.push_back(int'(o_bit));
                    bit_cyc.push_back(rel);
                    if (o_last) last_cyc = rel;
                end
            end
        end
    end

    task automatic clear_ctrl();
        en_a = 0; en_b = 0; en2_a = 0; en2_b = 0;
        rdy_a = 0; rdy_b = 0; bs1 = 0; bs2 = 0; rst_at = 0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_rd_en"}, o_rd_en, 0);
        check({tag, "_rd_addr"}, o_rd_addr, 0);
        check({tag, "_rd_st"}, o_rd_st, 0);
        check({tag, "_bit"}, o_bit, 0);
        check({tag, "_valid"}, o_valid, 0);
        check({tag, "_last"}, o_last, 0);
        check({tag, "_busy"}, o_busy, 0);
    endtask

    task automatic run_window(input logic [1:0] st, input int len);
        int n;
        rd_cyc.delete(); rd_addr_log.delete(); bit_log.delete(); bit_cyc.delete();
        last_cyc = -1;
        done_cyc = -1;
        model_load(st, len);
        @(posedge clk); #1;
        i_start = 1'b1; i_start_st = st; i_len = LEN_W'(len); en_tb = 1'b1; i_ready = 1'b1;
        @(posedge clk); #1;
        t0 = cyc;
        i_start = 1'b0;
        for (int k = 0; k < 300; k++) begin
            n = cyc - t0 + 1;
            if (!o_busy) begin
                done_cyc = n;
                break;
            end
            en_tb   = !((n >= en_a && n <= en_b) || (n >= en2_a && n <= en2_b));
            i_ready = !(n >= rdy_a && n <= rdy_b);
            if (n == bs1 || n == bs2) begin
                i_start = 1'b1; i_start_st = ~st; i_len = 4'd4;
            end else begin
                i_start = 1'b0;
            end
            if (n == rst_at) begin
                #2 rst = 1'b0;
                #1 check_zero_outputs("async_rst");
                exp_addr.delete(); exp_st.delete(); exp_bit.delete(); exp_last.delete();
                repeat (2) @(posedge clk);
                #1 rst = 1'b1;
                check("rst_idle_busy", o_busy, 0);
                en_tb = 1'b1; i_ready = 1'b1; i_start = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        en_tb = 1'b1; i_ready = 1'b1; i_start = 1'b0;
        if (done_cyc < 0) check("timeout", 0, 1);
        check("left_reads", exp_addr.size(), 0);
        check("left_bits", exp_bit.size(), 0);
    endtask

    task automatic check_s1(input string tag);
        int e[8];
        e = '{1, 3, 5, 7, 0, 0, 0, 0};
        check_seq({tag, "_rd_cyc"}, rd_cyc, e, 4);
        e = '{3, 2, 1, 0, 0, 0, 0, 0};
        check_seq({tag, "_rd_addr"}, rd_addr_log, e, 4);
        e = '{1, 0, 1, 1, 0, 0, 0, 0};
        check_seq({tag, "_bits"}, bit_log, e, 4);
        e = '{9, 10, 11, 12, 0, 0, 0, 0};
        check_seq({tag, "_bit_cyc"}, bit_cyc, e, 4);
        check({tag, "_last_cyc"}, last_cyc, 12);
        check({tag, "_idle_cyc"}, done_cyc, 13);
    endtask

    initial begin
        int e[8];
        for (int t = 0; t < DEPTH; t++)
            for (int s = 0; s < 4; s++) mem[t][s] = 2'((t * 3 + s + 1) % 4);
        mem[0][2] = 2'b00;
        mem[1][1] = 2'b10;
        mem[2][2] = 2'b01;
        mem[3][3] = 2'b10;
        clear_ctrl();

        #2 check_zero_outputs("reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        check("post_reset_busy", o_busy, 0);

        // Basic trace
        run_window(2'b11, 4);
        check_s1("s1");

        // Backpressure in cycles 10-11
        clear_ctrl(); rdy_a = 10; rdy_b = 11;
        run_window(2'b11, 4);
        e = '{1, 0, 1, 1, 0, 0, 0, 0};
        check_seq("s2_bits", bit_log, e, 4);
        e = '{9, 12, 13, 14, 0, 0, 0, 0};
        check_seq("s2_bit_cyc", bit_cyc, e, 4);
        check("s2_last_cyc", last_cyc, 14);

        // Length bounds
        clear_ctrl();
        run_window(2'b11, 0);
        check("len0_reads", rd_cyc.size(), 0);
        check("len0_idle", done_cyc, 1);
        run_window(2'b01, 12);
        e = '{7, 6, 5, 4, 3, 2, 1, 0};
        check_seq("len12_addr", rd_addr_log, e, 8);
        check("len12_bits", bit_log.size(), 8);
        check("len12_idle", done_cyc, 25);
        run_window(2'b10, 1);
        e = '{0, 0, 0, 0, 0, 0, 0, 0};
        check_seq("len1_addr", rd_addr_log, e, 1);
        e = '{1, 0, 0, 0, 0, 0, 0, 0};
        check_seq("len1_bits", bit_log, e, 1);
        check("len1_last_cyc", last_cyc, 3);

        // Stall during an RD cycle and during EMIT
        clear_ctrl(); en_a = 3; en_b = 5; en2_a = 13; en2_b = 15;
        run_window(2'b11, 4);
        e = '{1, 6, 8, 10, 0, 0, 0, 0};
        check_seq("s4_rd_cyc", rd_cyc, e, 4);
        e = '{1, 0, 1, 1, 0, 0, 0, 0};
        check_seq("s4_bits", bit_log, e, 4);
        check("s4_last_cyc", last_cyc, 18);
        check("s4_idle_cyc", done_cyc, 19);

        // Start while busy, during CAP and during EMIT
        clear_ctrl(); bs1 = 2; bs2 = 10;
        run_window(2'b11, 4);
        check_s1("s5");

        // Reset during EMIT at oidx 2, then a clean window
        clear_ctrl(); rst_at = 11;
        run_window(2'b11, 4);
        clear_ctrl();
        run_window(2'b11, 4);
        check_s1("s6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
